// File: rtl/pipe_core.sv
// pipe_core: 4-stage IF/ID/EX/WB pipeline.
// Define PIPE_CORE_FWD_EN to forward EX results into ID instead of stalling on RAW hazards.
module pipe_core #(
  parameter int DW  = 8,
  parameter int RAW = 2,
  parameter int PAW = 4,
  parameter int DAW = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [PAW-1:0]        imem_addr,
  input  logic [3+RAW+DW-1:0]   imem_data,
  output logic [DAW-1:0]        dmem_addr,
  output logic [DW-1:0]         dmem_wdata,
  output logic                  dmem_we,
  input  logic [DW-1:0]         dmem_rdata,
  output logic                  halted,
  output logic                  retire_valid,
  output logic                  stall
);
  localparam int IW = 3 + RAW + DW;
  localparam logic [2:0] OP_NOP = 3'd0, OP_ADD = 3'd1, OP_LOAD = 3'd2, OP_STORE = 3'd3,
                         OP_LOADC = 3'd4, OP_SUB = 3'd5, OP_JMP = 3'd6, OP_HALT = 3'd7;
  function automatic logic f_writes(input logic [2:0] op);
    return op == OP_ADD || op == OP_SUB || op == OP_LOAD || op == OP_LOADC;
  endfunction
  logic [PAW-1:0] r_pc;
  logic           r_fetch_stop;
  logic           r_id_v, r_ex_v, r_wb_v, r_halted;
  logic [IW-1:0]  r_id_ir, r_ex_ir;
  logic [DW-1:0]  r_ex_a, r_ex_b, r_wb_res;
  logic [2:0]     r_wb_op;
  logic [RAW-1:0] r_wb_rd;
  logic [DW-1:0]  r_regs [2**RAW];
  logic [2:0]     w_id_op, w_ex_op;
  logic [RAW-1:0] w_id_rd, w_ex_rd, w_src_a, w_src_b;
  logic [DW-1:0]  w_id_imm, w_ex_imm, w_ex_res, w_rf_a, w_rf_b, w_op_a, w_op_b;
  logic           w_use_a, w_use_b, w_ex_wr, w_wb_wr, w_haz_a, w_haz_b;
  logic           w_stall, w_jmp, w_halt_id;
  always_comb begin
    w_id_op  = r_id_ir[IW-1 -: 3];
    w_id_rd  = r_id_ir[DW +: RAW];
    w_id_imm = r_id_ir[DW-1:0];
    w_ex_op  = r_ex_ir[IW-1 -: 3];
    w_ex_rd  = r_ex_ir[DW +: RAW];
    w_ex_imm = r_ex_ir[DW-1:0];
    // STORE reads its data register through the rd field
    w_use_a  = w_id_op == OP_ADD || w_id_op == OP_SUB || w_id_op == OP_STORE;
    w_use_b  = w_id_op == OP_ADD || w_id_op == OP_SUB;
    w_src_a  = w_id_op == OP_STORE ? w_id_rd : w_id_imm[2*RAW-1:RAW];
    w_src_b  = w_id_imm[RAW-1:0];
    w_ex_wr  = r_ex_v && f_writes(w_ex_op);
    w_wb_wr  = r_wb_v && f_writes(r_wb_op);
    w_ex_res = w_ex_op == OP_LOAD  ? dmem_rdata :
               w_ex_op == OP_LOADC ? w_ex_imm :
               w_ex_op == OP_SUB   ? r_ex_a - r_ex_b : r_ex_a + r_ex_b;
    w_rf_a   = (w_wb_wr && r_wb_rd == w_src_a) ? r_wb_res : r_regs[w_src_a];
    w_rf_b   = (w_wb_wr && r_wb_rd == w_src_b) ? r_wb_res : r_regs[w_src_b];
    w_haz_a  = r_id_v && w_use_a && w_ex_wr && w_ex_rd == w_src_a;
    w_haz_b  = r_id_v && w_use_b && w_ex_wr && w_ex_rd == w_src_b;
`ifdef PIPE_CORE_FWD_EN
    w_op_a   = w_haz_a ? w_ex_res : w_rf_a;
    w_op_b   = w_haz_b ? w_ex_res : w_rf_b;
    w_stall  = 1'b0;
`else
    w_op_a   = w_rf_a;
    w_op_b   = w_rf_b;
    w_stall  = w_haz_a || w_haz_b;
`endif
    w_jmp     = r_id_v && !w_stall && w_id_op == OP_JMP;
    w_halt_id = r_id_v && !w_stall && w_id_op == OP_HALT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= '0;
      r_fetch_stop <= 1'b0;
      r_id_v       <= 1'b0;
      r_ex_v       <= 1'b0;
      r_wb_v       <= 1'b0;
      r_halted     <= 1'b0;
      r_id_ir      <= '0;
      r_ex_ir      <= '0;
      r_ex_a       <= '0;
      r_ex_b       <= '0;
      r_wb_res     <= '0;
      r_wb_op      <= OP_NOP;
      r_wb_rd      <= '0;
      for (int i = 0; i < 2**RAW; i++) r_regs[i] <= '0;
    end else begin
      if (!w_stall) begin
        r_pc         <= w_jmp ? w_id_imm[PAW-1:0] : (w_halt_id || r_fetch_stop) ? r_pc : r_pc + 1'b1;
        r_fetch_stop <= r_fetch_stop || w_halt_id;
        r_id_v       <= !r_fetch_stop && !w_jmp && !w_halt_id;
        r_id_ir      <= imem_data;
      end
      r_ex_v   <= r_id_v && !w_stall;
      r_ex_ir  <= r_id_ir;
      r_ex_a   <= w_op_a;
      r_ex_b   <= w_op_b;
      r_wb_v   <= r_ex_v;
      r_wb_op  <= w_ex_op;
      r_wb_rd  <= w_ex_rd;
      r_wb_res <= w_ex_res;
      if (w_wb_wr) r_regs[r_wb_rd] <= r_wb_res;
      if (r_wb_v && r_wb_op == OP_HALT) r_halted <= 1'b1;
    end
  end
  assign imem_addr    = r_pc;
  assign dmem_addr    = w_ex_imm[DAW-1:0];
  assign dmem_wdata   = r_ex_a;
  assign dmem_we      = !rst && r_ex_v && w_ex_op == OP_STORE;
  assign halted       = !rst && (r_halted || (r_wb_v && r_wb_op == OP_HALT));
  assign retire_valid = !rst && r_wb_v && r_wb_op != OP_NOP;
  assign stall        = !rst && w_stall;
endmodule

// File: tb/tb_pipe_core.sv
// tb_pipe_core: directed and random programs checked against an instruction-level interpreter.
module tb_pipe_core;
  localparam int DW = 8, RAW = 2, PAW = 4, DAW = 4, IW = 3 + RAW + DW;
  localparam logic [2:0] NOP = 3'd0, ADD = 3'd1, LOAD = 3'd2, STORE = 3'd3,
                         LOADC = 3'd4, SUB = 3'd5, JMP = 3'd6, HALT = 3'd7;
  logic clk = 1'b0, rst = 1'b1;
  logic [PAW-1:0] imem_addr;
  logic [IW-1:0]  imem_data;
  logic [DAW-1:0] dmem_addr;
  logic [DW-1:0]  dmem_wdata, dmem_rdata;
  logic dmem_we, halted, retire_valid, stall;
  logic [IW-1:0] imem [16];
  logic [DW-1:0] dmem [16];
  logic [DW-1:0] dinit [16];
  int nvec = 0, nerr = 0;
  int cyc, ret_cnt, stall_cnt, halt_cyc, exp_ret;
  int st_q[$], exp_q[$];
  int trace [256];

  pipe_core dut (.clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
                 .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
                 .dmem_rdata(dmem_rdata), .halted(halted), .retire_valid(retire_valid), .stall(stall));

  always #5 clk = ~clk;
  assign imem_data  = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 16; i++) dmem[i] <= dinit[i];
    else if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
  end

  function automatic logic [IW-1:0] ins(input logic [2:0] op, input int rd, input int imm);
    return {op, RAW'(rd), DW'(imm)};
  endfunction

  function automatic int st_at(input int i);
    return i < st_q.size() ? st_q[i] : -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) imem[i] = ins(NOP, 0, 0);
    for (int i = 0; i < 16; i++) dinit[i] = DW'($urandom_range(0, 255));
  endtask

  task automatic clear_counts();
    cyc = 0; ret_cnt = 0; stall_cnt = 0; halt_cyc = -1;
    st_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_counts();
  endtask

  task automatic tick();
    #1;
    if (cyc < 256) trace[cyc] = int'(imem_addr);
    if (dmem_we) st_q.push_back(int'(dmem_addr) * 256 + int'(dmem_wdata));
    if (retire_valid) ret_cnt++;
    if (stall) stall_cnt++;
    if (halted && halt_cyc < 0) halt_cyc = cyc;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int budget);
    while (halt_cyc < 0 && cyc < budget) tick();
  endtask

  // architectural interpreter: one instruction per step, no pipeline notion
  task automatic model_run();
    logic [DW-1:0] r [4];
    logic [DW-1:0] m [16];
    logic [IW-1:0] w;
    logic [2:0] op;
    int pc, rd, a, b, imm;
    pc = 0;
    for (int i = 0; i < 4; i++) r[i] = '0;
    for (int i = 0; i < 16; i++) m[i] = dinit[i];
    exp_q.delete();
    exp_ret = 0;
    for (int s = 0; s < 100; s++) begin
      w = imem[pc];
      op = w[IW-1 -: 3];
      rd = int'(w[DW +: RAW]);
      imm = int'(w[DW-1:0]);
      a = (imm / 4) % 4;
      b = imm % 4;
      if (op != NOP) exp_ret++;
      if (op == HALT) break;
      if (op == ADD) r[rd] = r[a] + r[b];
      else if (op == SUB) r[rd] = r[a] - r[b];
      else if (op == LOAD) r[rd] = m[imm % 16];
      else if (op == LOADC) r[rd] = DW'(imm);
      else if (op == STORE) begin
        m[imm % 16] = r[rd];
        exp_q.push_back((imm % 16) * 256 + int'(r[rd]));
      end
      pc = (op == JMP) ? imm % 16 : (pc + 1) % 16;
    end
  endtask

  task automatic check_run(input string tag);
    chk({tag, "_halted"}, halt_cyc >= 0, 1);
    chk({tag, "_retired"}, ret_cnt, exp_ret);
    chk({tag, "_nstores"}, st_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) chk({tag, "_store"}, st_at(i), exp_q[i]);
`ifdef PIPE_CORE_FWD_EN
    chk({tag, "_nostall"}, stall_cnt, 0);
`endif
  endtask

  initial begin
    int op, imm;
    clear_prog();
    @(negedge clk);
    #1;
    chk("rst_pc", imem_addr, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retire", retire_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_we", dmem_we, 0);

    // free-running NOPs: PC wraps 15 -> 0
    do_reset();
    run(17);
    chk("wrap_first", trace[0], 0);
    chk("wrap_15", trace[15], 15);
    chk("wrap_16", trace[16], 0);
    chk("wrap_noretire", ret_cnt, 0);

    // back-to-back dependent ALU ops
    clear_prog();
    imem[0] = ins(LOADC, 1, 3);
    imem[1] = ins(LOADC, 2, 5);
    imem[2] = ins(ADD, 3, 6);
    imem[3] = ins(STORE, 3, 0);
    imem[4] = ins(HALT, 0, 0);
    do_reset();
    run(100);
    chk("add_nst", st_q.size(), 1);
    chk("add_r3", st_at(0), 8);
    chk("add_ret", ret_cnt, 5);
`ifdef PIPE_CORE_FWD_EN
    chk("add_stall", stall_cnt, 0);
`else
    chk("add_stall", stall_cnt, 2);
`endif

    // modulo arithmetic
    clear_prog();
    imem[0] = ins(LOADC, 0, 200);
    imem[1] = ins(LOADC, 1, 100);
    imem[2] = ins(ADD, 2, 1);
    imem[3] = ins(SUB, 3, 4);
    imem[4] = ins(STORE, 2, 0);
    imem[5] = ins(STORE, 3, 1);
    imem[6] = ins(HALT, 0, 0);
    do_reset();
    run(100);
    chk("wrap_nst", st_q.size(), 2);
    chk("wrap_add", st_at(0), 0 * 256 + 44);
    chk("wrap_sub", st_at(1), 1 * 256 + 156);

    // load then store of the loaded value
    clear_prog();
    dinit[7] = 8'd9;
    imem[0] = ins(LOAD, 1, 7);
    imem[1] = ins(STORE, 1, 2);
    imem[2] = ins(HALT, 0, 0);
    do_reset();
    run(100);
    chk("ldst_nst", st_q.size(), 1);
    chk("ldst_val", st_at(0), 2 * 256 + 9);
    chk("ldst_ret", ret_cnt, 3);

    // jump squashes the next sequential slot
    clear_prog();
    imem[3]  = ins(JMP, 0, 10);
    imem[4]  = ins(STORE, 0, 5);
    imem[10] = ins(HALT, 0, 0);
    do_reset();
    run(100);
    chk("jmp_pc4", trace[4], 4);
    chk("jmp_pc5", trace[5], 10);
    chk("jmp_nst", st_q.size(), 0);
    chk("jmp_ret", ret_cnt, 2);

    // HALT at the last address after NOPs
    clear_prog();
    imem[15] = ins(HALT, 0, 0);
    do_reset();
    run(100);
    chk("halt_cyc", halt_cyc, 18);
    chk("halt_ret", ret_cnt, 1);
    repeat (4) tick();
    #1;
    chk("halt_pc_frozen", imem_addr, 0);
    chk("halt_held", halted, 1);
    do_reset();
    #1;
    chk("halt_rst_pc", imem_addr, 0);
    chk("halt_rst_flag", halted, 0);

    // reset while a STORE sits in ID
    clear_prog();
    imem[0]  = ins(LOADC, 0, 55);
    imem[1]  = ins(STORE, 0, 3);
    imem[15] = ins(HALT, 0, 0);
    @(negedge clk);
    do_reset();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rstmid_we0", dmem_we, 0);
    @(negedge clk);
    #1;
    chk("rstmid_we1", dmem_we, 0);
    chk("rstmid_pc", imem_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_counts();
    run(100);
    chk("rstmid_first", trace[0], 0);
    chk("rstmid_nst", st_q.size(), 1);
    chk("rstmid_st", st_at(0), 3 * 256 + 55);
    chk("rstmid_ret", ret_cnt, 3);

    // random programs: forward jumps only, registers dumped to memory before HALT
    for (int t = 0; t < 12; t++) begin
      clear_prog();
      for (int a = 0; a < 11; a++) begin
        op  = $urandom_range(0, 6);
        imm = (op == 6) ? $urandom_range(a + 1, 11) : $urandom_range(0, 255);
        imem[a] = ins(3'(op), $urandom_range(0, 3), imm);
      end
      for (int i = 0; i < 4; i++) imem[11 + i] = ins(STORE, i, 12 + i);
      imem[15] = ins(HALT, 0, 0);
      model_run();
      do_reset();
      run(300);
      check_run("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/pipe_core.md
PIPE_CORE -- requirements
Module: pipe_core

Interface
REQ-001 SHALL have parameter DW, default 8: data and register width.
REQ-002 SHALL have parameter RAW, default 2: register address width (2^RAW registers).
REQ-003 SHALL have parameter PAW, default 4: program address width.
REQ-004 SHALL have parameter DAW, default 4: data address width; DW >= 2*RAW and DW >= DAW.
REQ-005 SHALL derive IW = 3+RAW+DW; instruction = opcode[IW-1:IW-3] | rd[RAW] | imm[DW]; rs1 = imm[2*RAW-1:RAW], rs2 = imm[RAW-1:0].
REQ-006 SHALL have ports: clk in 1, clock; rst in 1, reset, synchronous, active-high.
REQ-007 SHALL have ports: imem_addr out PAW, fetch address; imem_data in IW, instruction (combinational read).
REQ-008 SHALL have ports: dmem_addr out DAW; dmem_wdata out DW; dmem_we out 1; dmem_rdata in DW (combinational read, write at clk edge).
REQ-009 SHALL have ports: halted out 1, HALT retired; retire_valid out 1, non-NOP retired this cycle; stall out 1, decode stalled this cycle.

Function
REQ-010 SHALL implement four stages IF, ID, EX, WB, each with a registered instruction and a valid bit.
REQ-011 SHALL decode opcodes: 000 NOP, 001 ADD rd=rs1+rs2, 010 LOAD rd=M[imm], 011 STORE M[imm]=rd, 100 LOADC rd=imm, 101 SUB rd=rs1-rs2, 110 JMP pc=imm[PAW-1:0], 111 HALT.
REQ-012 SHALL truncate ADD/SUB results modulo 2^DW; no flags.
REQ-013 SHALL increment PC modulo 2^PAW each unstalled cycle (15 wraps to 0 at PAW=4).
REQ-014 SHALL, in steady state without hazards, write rd at the end of cycle n+3 for an instruction fetched in cycle n.
REQ-015 SHALL drive dmem_we=1, dmem_addr=imm[DAW-1:0], dmem_wdata=rd value for exactly the one cycle a valid STORE is in EX; dmem_we=0 otherwise.
REQ-016 SHALL sample dmem_rdata in EX for LOAD and write it to rd in WB.
REQ-017 SHALL make a register written in WB visible to an ID read in the same cycle (write-through).
REQ-018 SHALL resolve JMP in ID: PC <= target, IF instruction squashed (one bubble), no other side effect.
REQ-019 SHALL, on HALT in ID, freeze PC and squash IF; older instructions drain; halted rises the cycle HALT leaves WB and holds until rst.
REQ-020 SHALL treat an ID source (rs1/rs2 for ADD/SUB, rd for STORE) equal to a valid EX destination (ADD, SUB, LOAD, LOADC) as a RAW hazard; register 0 is a normal register.
REQ-021 SHALL, while stall=1, hold PC and IF/ID, inject a bubble into EX, and let EX/WB advance.
REQ-022 SHALL give JMP/HALT in ID priority over PC increment; a stalled JMP/HALT takes effect only when the stall clears.
REQ-023 SHALL assert retire_valid one cycle per retired ADD, SUB, LOAD, LOADC, STORE, JMP, HALT; never for bubbles or squashed slots.

Reset
REQ-024 SHALL on rst clear PC, all valid bits, registers, halted, retire_valid, stall, and dmem_we to 0.
REQ-025 SHALL let rst mid-operation abandon all in-flight instructions; no dmem write in the cycle rst is high.
REQ-026 SHALL fetch address 0 in the first cycle after rst deasserts.

Configuration
REQ-027 SHALL, with PIPE_CORE_FWD_EN defined, forward the EX result (ALU, imm, or dmem_rdata) into ID operands; stall is constant 0.
REQ-028 SHALL, without PIPE_CORE_FWD_EN, stall one cycle per RAW hazard per REQ-020/REQ-021; architectural results identical.

Verification
REQ-029 SHALL cover: LOADC r1,3; LOADC r2,5; ADD r3,r1,r2 -> r3=8; with FWD stall never 1; without FWD stall pulses, r3 still 8.
REQ-030 SHALL cover: LOADC r0,200; LOADC r1,100; ADD r2,r0,r1 (DW=8) -> r2=44; SUB r3,r1,r0 -> r3=156.
REQ-031 SHALL cover: dmem[7]=9; LOAD r1,7; STORE r1,2 -> one dmem_we pulse, addr 2, wdata 9.
REQ-032 SHALL cover: JMP 10 at address 3 -> instruction at 4 never retires; next fetch address 10.
REQ-033 SHALL cover: HALT at 15 after NOPs -> halted rises 3 cycles after HALT fetch, PC frozen; rst -> PC=0, halted=0.
REQ-034 SHALL cover: rst asserted while STORE in ID -> no dmem_we; execution restarts at address 0.
